// File: rtl/ram_burst_ctrl_pkg.sv
// rtl/ram_burst_ctrl_pkg.sv - shared state encoding and default widths for ram_burst_ctrl
package ram_burst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_e;

  localparam int DEF_RAM_ADDR_WIDTH = 8;
  localparam int DEF_RAM_DATA_WIDTH = 32;
  localparam int DEF_LEN_WIDTH      = 8;

endpackage

// File: rtl/ram_burst_addr_gen.sv
// rtl/ram_burst_addr_gen.sv - burst address pointer and remaining-beat counter
module ram_burst_addr_gen
  import ram_burst_ctrl_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = DEF_RAM_ADDR_WIDTH,
  parameter int LEN_WIDTH      = DEF_LEN_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_i,
  input  logic [RAM_ADDR_WIDTH-1:0] addr_i,
  input  logic [LEN_WIDTH-1:0]      len_i,
  input  logic                      adv_i,
  output logic [RAM_ADDR_WIDTH-1:0] addr_o,
  output logic                      last_o
);

  logic [RAM_ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [LEN_WIDTH-1:0]      cnt_q, cnt_d;

  // Pointer wraps modulo depth through natural overflow.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      ptr_d = addr_i;
      cnt_d = len_i;
    end else if (adv_i) begin
      ptr_d = ptr_q + 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  assign addr_o = ptr_q;
  assign last_o = (cnt_q == '0);

endmodule

// File: rtl/ram_burst_ctrl.sv
// rtl/ram_burst_ctrl.sv - burst read/write controller for a single-port RAM
// Optional RAM_BURST_CTRL_NOWRAP_EN: reject bursts crossing the top of RAM via o_cmd_err.
module ram_burst_ctrl
  import ram_burst_ctrl_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = DEF_RAM_ADDR_WIDTH,
  parameter int RAM_DATA_WIDTH = DEF_RAM_DATA_WIDTH,
  parameter int LEN_WIDTH      = DEF_LEN_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_cmd_valid,
  output logic                      o_cmd_ready,
  input  logic                      i_cmd_wr,
  input  logic [RAM_ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [LEN_WIDTH-1:0]      i_cmd_len,
  input  logic                      i_wr_valid,
  output logic                      o_wr_ready,
  input  logic [RAM_DATA_WIDTH-1:0] i_wr_data,
  output logic                      o_rd_valid,
  input  logic                      i_rd_ready,
  output logic [RAM_DATA_WIDTH-1:0] o_rd_data,
  output logic                      o_ram_we,
  output logic [RAM_ADDR_WIDTH-1:0] o_ram_addr,
  output logic [RAM_DATA_WIDTH-1:0] o_ram_wr_data,
  input  logic [RAM_DATA_WIDTH-1:0] i_ram_rd_data,
  output logic                      o_busy
`ifdef RAM_BURST_CTRL_NOWRAP_EN
  , output logic                    o_cmd_err
`endif
);

  state_e                    state_q;
  logic                      rd_valid_q;
  logic [RAM_DATA_WIDTH-1:0] rd_data_q;
  logic                      cmd_hs;
  logic                      cmd_bad;
  logic                      wr_beat;
  logic                      rd_load;
  logic                      ag_last;
  logic [RAM_ADDR_WIDTH-1:0] ag_addr;

`ifdef RAM_BURST_CTRL_NOWRAP_EN
  localparam int SUM_W = ((RAM_ADDR_WIDTH > LEN_WIDTH) ? RAM_ADDR_WIDTH : LEN_WIDTH) + 2;
  localparam logic [SUM_W-1:0] DEPTH_W = SUM_W'(2 ** RAM_ADDR_WIDTH);
  logic [SUM_W-1:0] burst_end;
  logic             cmd_err_q;

  assign burst_end = SUM_W'(i_cmd_addr) + SUM_W'(i_cmd_len) + SUM_W'(1);
  assign cmd_bad   = (burst_end > DEPTH_W);
  assign o_cmd_err = cmd_err_q;
`else
  assign cmd_bad = 1'b0;
`endif

  assign cmd_hs  = i_cmd_valid & o_cmd_ready;
  assign wr_beat = (state_q == ST_WRITE) & i_wr_valid;
  assign rd_load = (state_q == ST_READ) & (~rd_valid_q | i_rd_ready);

  ram_burst_addr_gen #(
    .RAM_ADDR_WIDTH (RAM_ADDR_WIDTH),
    .LEN_WIDTH      (LEN_WIDTH)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .load_i (cmd_hs & ~cmd_bad),
    .addr_i (i_cmd_addr),
    .len_i  (i_cmd_len),
    .adv_i  (wr_beat | rd_load),
    .addr_o (ag_addr),
    .last_o (ag_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
`ifdef RAM_BURST_CTRL_NOWRAP_EN
      cmd_err_q  <= 1'b0;
`endif
    end else begin
`ifdef RAM_BURST_CTRL_NOWRAP_EN
      cmd_err_q <= cmd_hs & cmd_bad;
`endif
      case (state_q)
        ST_IDLE:  if (cmd_hs && !cmd_bad) state_q <= i_cmd_wr ? ST_WRITE : ST_READ;
        ST_WRITE: if (wr_beat && ag_last) state_q <= ST_IDLE;
        ST_READ:  if (rd_load && ag_last) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
      // A pending read beat may drain in IDLE while the next command is taken.
      if (rd_load) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= i_ram_rd_data;
      end else if (i_rd_ready) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  assign o_cmd_ready   = (state_q == ST_IDLE);
  assign o_busy        = (state_q != ST_IDLE);
  assign o_wr_ready    = (state_q == ST_WRITE);
  assign o_ram_we      = wr_beat & ~rst;
  assign o_ram_addr    = ag_addr;
  assign o_ram_wr_data = i_wr_data;
  assign o_rd_valid    = rd_valid_q;
  assign o_rd_data     = rd_data_q;

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// tb/tb_ram_burst_ctrl.sv - directed self-checking bench for ram_burst_ctrl
module tb_ram_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_cmd_valid, o_cmd_ready, i_cmd_wr;
  logic [7:0]  i_cmd_addr, i_cmd_len;
  logic        i_wr_valid, o_wr_ready;
  logic [31:0] i_wr_data;
  logic        o_rd_valid, i_rd_ready;
  logic [31:0] o_rd_data;
  logic        o_ram_we;
  logic [7:0]  o_ram_addr;
  logic [31:0] o_ram_wr_data, i_ram_rd_data;
  logic        o_busy;
`ifdef RAM_BURST_CTRL_NOWRAP_EN
  logic        o_cmd_err;
`endif

  int checks = 0;
  int failures = 0;
  int wr_count = 0;
  logic [31:0] mem [256];

  always #5 clk = ~clk;

  ram_burst_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_wr      (i_cmd_wr),
    .i_cmd_addr    (i_cmd_addr),
    .i_cmd_len     (i_cmd_len),
    .i_wr_valid    (i_wr_valid),
    .o_wr_ready    (o_wr_ready),
    .i_wr_data     (i_wr_data),
    .o_rd_valid    (o_rd_valid),
    .i_rd_ready    (i_rd_ready),
    .o_rd_data     (o_rd_data),
    .o_ram_we      (o_ram_we),
    .o_ram_addr    (o_ram_addr),
    .o_ram_wr_data (o_ram_wr_data),
    .i_ram_rd_data (i_ram_rd_data),
    .o_busy        (o_busy)
`ifdef RAM_BURST_CTRL_NOWRAP_EN
    , .o_cmd_err   (o_cmd_err)
`endif
  );

  always @(posedge clk) begin
    if (o_ram_we) begin
      mem[o_ram_addr] <= o_ram_wr_data;
      wr_count <= wr_count + 1;
    end
  end
  assign i_ram_rd_data = mem[o_ram_addr];

  task automatic issue_cmd(input logic wr, input logic [7:0] addr, input logic [7:0] len);
    @(negedge clk);
    i_cmd_valid = 1'b1;
    i_cmd_wr    = wr;
    i_cmd_addr  = addr;
    i_cmd_len   = len;
    #1;
    checks++;
    if (o_cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL cmd_ready actual=%b expected=1", o_cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    i_cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({o_cmd_ready, o_busy, o_rd_valid, o_ram_we, o_wr_ready} !== 5'b10000 || o_rd_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_state actual=%b/%h expected=10000/0",
               {o_cmd_ready, o_busy, o_rd_valid, o_ram_we, o_wr_ready}, o_rd_data);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_burst();
    issue_cmd(1'b1, 8'h10, 8'd3);
    checks++;
    if (o_busy !== 1'b1 || o_wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL wr_state busy=%b wr_ready=%b expected=1/1", o_busy, o_wr_ready);
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      i_wr_valid = 1'b1;
      i_wr_data  = 32'hA0 + i;
      #1;
      checks++;
      if (o_ram_we !== 1'b1 || o_ram_addr !== 8'(8'h10 + i)) begin
        failures++;
        $display("FAIL wr_beat%0d we=%b addr=%h expected=1/%h", i, o_ram_we, o_ram_addr, 8'h10 + i);
      end
      @(posedge clk);
    end
    @(negedge clk);
    i_wr_valid = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_ram_we !== 1'b0) begin
      failures++;
      $display("FAIL wr_done busy=%b we=%b expected=0/0", o_busy, o_ram_we);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[8'h10 + i] !== 32'hA0 + i) begin
        failures++;
        $display("FAIL wr_mem%0d actual=%h expected=%h", i, mem[8'h10 + i], 32'hA0 + i);
      end
    end
  endtask

  task automatic test_read_burst();
    i_rd_ready = 1'b1;
    issue_cmd(1'b0, 8'h10, 8'd3);
    checks++;
    if (o_rd_valid !== 1'b0 || o_busy !== 1'b1) begin
      failures++;
      $display("FAIL rd_t0 valid=%b busy=%b expected=0/1", o_rd_valid, o_busy);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (o_rd_valid !== 1'b1 || o_rd_data !== 32'hA0 + i) begin
        failures++;
        $display("FAIL rd_beat%0d valid=%b data=%h expected=1/%h", i, o_rd_valid, o_rd_data, 32'hA0 + i);
      end
    end
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("FAIL rd_idle busy=%b expected=0", o_busy);
    end
    @(negedge clk);
    checks++;
    if (o_rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL rd_drain valid=%b expected=0", o_rd_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got [$];
    int stalls = 0;
    i_rd_ready = 1'b1;
    issue_cmd(1'b0, 8'h10, 8'd3);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      i_rd_ready = 1'b1;
      if (o_rd_valid && got.size() == 1 && stalls < 3) begin
        i_rd_ready = 1'b0;
        stalls++;
        checks++;
        if (o_rd_data !== 32'hA1) begin
          failures++;
          $display("FAIL bp_hold%0d actual=%h expected=000000a1", stalls, o_rd_data);
        end
      end
      if (o_rd_valid && i_rd_ready) got.push_back(o_rd_data);
    end
    i_rd_ready = 1'b1;
    checks++;
    if (got.size() != 4 || stalls != 3) begin
      failures++;
      $display("FAIL bp_count beats=%0d stalls=%0d expected=4/3", got.size(), stalls);
    end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      checks++;
      if (got[i] !== 32'hA0 + i) begin
        failures++;
        $display("FAIL bp_beat%0d actual=%h expected=%h", i, got[i], 32'hA0 + i);
      end
    end
  endtask

  task automatic test_wrap();
    int wc0;
    logic [7:0] exp_addr [4];
    exp_addr[0] = 8'hFE; exp_addr[1] = 8'hFF; exp_addr[2] = 8'h00; exp_addr[3] = 8'h01;
    wc0 = wr_count;
    issue_cmd(1'b1, 8'hFE, 8'd3);
`ifdef RAM_BURST_CTRL_NOWRAP_EN
    i_wr_valid = 1'b1;
    i_wr_data  = 32'hB0;
    #1;
    checks++;
    if (o_cmd_err !== 1'b1 || o_busy !== 1'b0 || o_ram_we !== 1'b0) begin
      failures++;
      $display("FAIL nowrap_err err=%b busy=%b we=%b expected=1/0/0", o_cmd_err, o_busy, o_ram_we);
    end
    @(negedge clk);
    checks++;
    if (o_cmd_err !== 1'b0 || wr_count != wc0) begin
      failures++;
      $display("FAIL nowrap_pulse err=%b writes=%0d expected=0/0", o_cmd_err, wr_count - wc0);
    end
    i_wr_valid = 1'b0;
`else
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      i_wr_valid = 1'b1;
      i_wr_data  = 32'hB0 + i;
      #1;
      checks++;
      if (o_ram_we !== 1'b1 || o_ram_addr !== exp_addr[i]) begin
        failures++;
        $display("FAIL wrap_beat%0d we=%b addr=%h expected=1/%h", i, o_ram_we, o_ram_addr, exp_addr[i]);
      end
      @(posedge clk);
    end
    @(negedge clk);
    i_wr_valid = 1'b0;
    checks++;
    if (mem[8'h00] !== 32'hB2 || mem[8'h01] !== 32'hB3 || wr_count != wc0 + 4) begin
      failures++;
      $display("FAIL wrap_mem m0=%h m1=%h writes=%0d expected=b2/b3/4", mem[8'h00], mem[8'h01], wr_count - wc0);
    end
`endif
  endtask

  task automatic test_write_gaps();
    int wc0;
    logic [2:0] pat;
    pat = 3'b101;
    wc0 = wr_count;
    issue_cmd(1'b1, 8'h40, 8'd1);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      i_wr_valid = pat[i];
      i_wr_data  = (i == 0) ? 32'hC0 : 32'hC1;
      #1;
      checks++;
      if (o_ram_we !== pat[i] || o_busy !== 1'b1) begin
        failures++;
        $display("FAIL gap_cyc%0d we=%b busy=%b expected=%b/1", i, o_ram_we, o_busy, pat[i]);
      end
      @(posedge clk);
    end
    @(negedge clk);
    i_wr_valid = 1'b1;
    i_wr_data  = 32'hCF;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_ram_we !== 1'b0 || wr_count != wc0 + 2
        || mem[8'h40] !== 32'hC0 || mem[8'h41] !== 32'hC1) begin
      failures++;
      $display("FAIL gap_done busy=%b we=%b writes=%0d m40=%h m41=%h expected=0/0/2/c0/c1",
               o_busy, o_ram_we, wr_count - wc0, mem[8'h40], mem[8'h41]);
    end
    i_wr_valid = 1'b0;
  endtask

  task automatic test_single_beat();
    int wc0;
    wc0 = wr_count;
    issue_cmd(1'b1, 8'h50, 8'd0);
    i_wr_valid = 1'b1;
    i_wr_data  = 32'hE0;
    @(posedge clk);
    @(negedge clk);
    i_wr_data = 32'hEF;
    #1;
    checks++;
    if (o_busy !== 1'b0 || wr_count != wc0 + 1 || mem[8'h50] !== 32'hE0 || mem[8'h51] !== 32'h0) begin
      failures++;
      $display("FAIL single busy=%b writes=%0d m50=%h m51=%h expected=0/1/e0/0",
               o_busy, wr_count - wc0, mem[8'h50], mem[8'h51]);
    end
    i_wr_valid = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    issue_cmd(1'b1, 8'h80, 8'd7);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      i_wr_valid = 1'b1;
      i_wr_data  = 32'hD0 + i;
      @(posedge clk);
    end
    @(negedge clk);
    i_wr_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    i_wr_valid = 1'b1;
    i_wr_data  = 32'hDD;
    #1;
    checks++;
    if (o_busy !== 1'b0 || o_ram_we !== 1'b0 || o_cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid busy=%b we=%b cmd_ready=%b expected=0/0/1", o_busy, o_ram_we, o_cmd_ready);
    end
    @(negedge clk);
    i_wr_valid = 1'b0;
    checks++;
    if (mem[8'h80] !== 32'hD0 || mem[8'h81] !== 32'hD1 || mem[8'h82] !== 32'h0) begin
      failures++;
      $display("FAIL rst_mem m80=%h m81=%h m82=%h expected=d0/d1/0", mem[8'h80], mem[8'h81], mem[8'h82]);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_wr = 1'b0;
    i_cmd_addr = '0;
    i_cmd_len = '0;
    i_wr_valid = 1'b0;
    i_wr_data = '0;
    i_rd_ready = 1'b1;
    test_reset();
    test_write_burst();
    test_read_burst();
    test_backpressure();
    test_wrap();
    test_write_gaps();
    test_single_beat();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout elapsed=200000 expected=finish");
    $fatal(1);
  end

endmodule
